stim_trigger_gen: RTL and testbench

// - Downstream of the window-discriminator FSM. Turns the discriminator's one-sample "stim" state into a timed TTL stimulation pulse train.
// - Train has a programmable delay, pulse width, period and count, followed by a refractory lockout.
// - Runs on dataclk. All timing is counted in sample ticks, one per rising edge of sample_CLK_out.

---
 rtl/stim_trig_pkg.sv | 16 +
 rtl/stim_trigger_gen_if.sv | 28 ++
 rtl/sample_tick_detect.sv | 21 ++
 rtl/stim_trigger_gen.sv | 152 +++++++++++++++
 tb/tb_stim_trigger_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stim_trig_pkg.sv
// rtl/stim_trig_pkg.sv - shared state encoding and default widths for the stimulation trigger generator
package stim_trig_pkg;

    localparam int TW_DEFAULT = 16;
    localparam int NW_DEFAULT = 8;
    localparam int MW_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DELAY    = 3'd1,
        PULSE_HI = 3'd2,
        PULSE_LO = 3'd3,
        REFRACT  = 3'd4
    } stim_state_e;

endpackage

// File: rtl/stim_trigger_gen_if.sv
// rtl/stim_trigger_gen_if.sv - trigger, train configuration and status bundle of stim_trigger_gen
interface stim_trigger_gen_if #(
    parameter int TW = 16,
    parameter int NW = 8,
    parameter int MW = 16
);
    logic          stim_event;
    logic          enable;
    logic [TW-1:0] delay_samples;
    logic [TW-1:0] pulse_width;
    logic [TW-1:0] pulse_period;
    logic [NW-1:0] pulse_count;
    logic [TW-1:0] refractory;
    logic          stim_out;
    logic          busy;
    logic [NW-1:0] stim_index;
    logic [MW-1:0] missed_count;

    modport master (
        output stim_event, enable, delay_samples, pulse_width, pulse_period, pulse_count, refractory,
        input  stim_out, busy, stim_index, missed_count
    );

    modport slave (
        input  stim_event, enable, delay_samples, pulse_width, pulse_period, pulse_count, refractory,
        output stim_out, busy, stim_index, missed_count
    );
endinterface

// File: rtl/sample_tick_detect.sv
// rtl/sample_tick_detect.sv - one-cycle tick on each rising edge of the sample clock, seen from dataclk
module sample_tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic sample_clk_i,
    output logic tick_o
);
    logic sample_clk_dly_q;

    // Resets high so a sample clock already high at release does not look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_clk_dly_q <= 1'b1;
        end else begin
            sample_clk_dly_q <= sample_clk_i;
        end
    end

    assign tick_o = sample_clk_i & ~sample_clk_dly_q;

endmodule

// File: rtl/stim_trigger_gen.sv
// rtl/stim_trigger_gen.sv - timed TTL stimulation pulse train with refractory lockout, counted in sample ticks
// Optional saturating missed-trigger counter: STIM_TRIGGER_MISSED_COUNT_EN.
module stim_trigger_gen
    import stim_trig_pkg::*;
#(
    parameter int TW = TW_DEFAULT,
    parameter int NW = NW_DEFAULT,
    parameter int MW = MW_DEFAULT
) (
    input  logic              dataclk,
    input  logic              reset,
    input  logic              sample_clk,
    stim_trigger_gen_if.slave bus
);
    localparam logic [TW-1:0] ONE_T = TW'(1);
    localparam logic [NW-1:0] ONE_N = NW'(1);

    logic tick;

    sample_tick_detect u_tick (
        .clk          (dataclk),
        .rst          (reset),
        .sample_clk_i (sample_clk),
        .tick_o       (tick)
    );

    stim_state_e   state_q;
    logic [TW-1:0] cnt_q;
    logic [TW-1:0] width_q;
    logic [TW-1:0] low_q;
    logic [TW-1:0] refr_q;
    logic [NW-1:0] count_q;
    logic [NW-1:0] index_q;
    logic          stim_q;
    logic          busy_q;

    logic [TW-1:0] width_in;
    logic [TW-1:0] low_in;
    logic [NW-1:0] count_in;
    logic          cnt_last;

    // Zero width/count mean one; a period not longer than the pulse still leaves a one-tick gap.
    always_comb begin
        width_in = (bus.pulse_width == '0) ? ONE_T : bus.pulse_width;
        count_in = (bus.pulse_count == '0) ? ONE_N : bus.pulse_count;
        low_in   = (bus.pulse_period > width_in) ? (bus.pulse_period - width_in) : ONE_T;
        cnt_last = (cnt_q == ONE_T);
    end

`ifdef STIM_TRIGGER_MISSED_COUNT_EN
    logic [MW-1:0] missed_q;
`endif

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            width_q  <= ONE_T;
            low_q    <= ONE_T;
            refr_q   <= '0;
            count_q  <= ONE_N;
            index_q  <= '0;
            stim_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef STIM_TRIGGER_MISSED_COUNT_EN
            missed_q <= '0;
`endif
        end else begin
`ifdef STIM_TRIGGER_MISSED_COUNT_EN
            if (tick && bus.enable && bus.stim_event && (state_q != IDLE) && (missed_q != '1)) begin
                missed_q <= missed_q + 1'b1;
            end
`endif
            if (!bus.enable) begin
                state_q <= IDLE;
                stim_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (tick) begin
                // Later loads in the case override this decrement.
                if (state_q != IDLE) begin
                    cnt_q <= cnt_q - ONE_T;
                end
                case (state_q)
                    IDLE: begin
                        if (bus.stim_event) begin
                            width_q <= width_in;
                            low_q   <= low_in;
                            count_q <= count_in;
                            refr_q  <= bus.refractory;
                            busy_q  <= 1'b1;
                            if (bus.delay_samples != '0) begin
                                state_q <= DELAY;
                                cnt_q   <= bus.delay_samples;
                                index_q <= '0;
                            end else begin
                                state_q <= PULSE_HI;
                                cnt_q   <= width_in;
                                stim_q  <= 1'b1;
                                index_q <= ONE_N;
                            end
                        end
                    end
                    DELAY, PULSE_LO: begin
                        if (cnt_last) begin
                            state_q <= PULSE_HI;
                            cnt_q   <= width_q;
                            stim_q  <= 1'b1;
                            index_q <= index_q + 1'b1;
                        end
                    end
                    PULSE_HI: begin
                        if (cnt_last) begin
                            stim_q <= 1'b0;
                            if (index_q < count_q) begin
                                state_q <= PULSE_LO;
                                cnt_q   <= low_q;
                            end else if (refr_q != '0) begin
                                state_q <= REFRACT;
                                cnt_q   <= refr_q;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    REFRACT: begin
                        if (cnt_last) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        stim_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stim_out   = stim_q;
    assign bus.busy       = busy_q;
    assign bus.stim_index = index_q;

`ifdef STIM_TRIGGER_MISSED_COUNT_EN
    assign bus.missed_count = missed_q;
`else
    assign bus.missed_count = {MW{1'b0}};
`endif

endmodule

// File: tb/tb_stim_trigger_gen.sv
// tb/tb_stim_trigger_gen.sv - self-checking bench for stim_trigger_gen against a train-schedule model
module tb_stim_trigger_gen;
    localparam int TW = 16;
    localparam int NW = 8;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_clk = 1'b1;
    bit   hold_sclk = 1'b0;
    bit   cmp_en = 1'b0;

    stim_trigger_gen_if #(.TW(TW), .NW(NW), .MW(MW)) bus ();

    stim_trigger_gen #(.TW(TW), .NW(NW), .MW(MW)) dut (
        .dataclk    (clk),
        .reset      (reset),
        .sample_clk (sample_clk),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a train is a schedule of pulse starts s_i = d + i*(W+L), relative to the trigger tick.
    int unsigned tick_cnt = 0;
    int unsigned trig_tick = 0;
    int unsigned trig_seq = 0;
    int r, m_d, m_w, m_l, m_n, m_r;
    bit active, m_stim, m_busy, sclk_prev, tk;
    int m_index, m_missed;

    function automatic void eval_train();
        int per, s, last_end;
        per = m_w + m_l;
        m_stim = 1'b0;
        m_index = 0;
        for (int i = 0; i < m_n; i++) begin
            s = m_d + i * per;
            if (r >= s) m_index = i + 1;
            if (r >= s && r < s + m_w) m_stim = 1'b1;
        end
        last_end = m_d + (m_n - 1) * per + m_w;
        m_busy = (r < last_end + m_r);
        if (!m_busy) active = 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_prev = 1'b1;
            active = 1'b0;
            m_stim = 1'b0;
            m_busy = 1'b0;
            m_index = 0;
            m_missed = 0;
        end else begin
            tk = sample_clk && !sclk_prev;
            sclk_prev = sample_clk;
            if (tk) tick_cnt++;
            if (!bus.enable) begin
                active = 1'b0;
                m_stim = 1'b0;
                m_busy = 1'b0;
            end else if (tk) begin
                if (active) begin
                    if (bus.stim_event && m_missed < (1 << MW) - 1) m_missed++;
                    r++;
                    eval_train();
                end else if (bus.stim_event) begin
                    m_d = int'(bus.delay_samples);
                    m_w = (bus.pulse_width == 0) ? 1 : int'(bus.pulse_width);
                    m_n = (bus.pulse_count == 0) ? 1 : int'(bus.pulse_count);
                    m_l = (int'(bus.pulse_period) > m_w) ? int'(bus.pulse_period) - m_w : 1;
                    m_r = int'(bus.refractory);
                    trig_tick = tick_cnt;
                    trig_seq++;
                    r = 0;
                    active = 1'b1;
                    eval_train();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stim_out", bus.stim_out, m_stim);
            chk("busy", bus.busy, m_busy);
            chk("stim_index", bus.stim_index, m_index);
`ifdef STIM_TRIGGER_MISSED_COUNT_EN
            chk("missed_count", bus.missed_count, m_missed);
`else
            chk("missed_count", bus.missed_count, 0);
`endif
        end
    end

    // Sample clock with random 1..3 cycle phases, so ticks are irregular in dataclk time.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (hold_sclk) sample_clk = 1'b1;
            else if (ph == 0) begin
                sample_clk = ~sample_clk;
                ph = $urandom_range(0, 2);
            end else ph--;
        end
    end

    task automatic set_cfg(input int d, input int w, input int p, input int c, input int rf);
        bus.delay_samples = TW'(d);
        bus.pulse_width   = TW'(w);
        bus.pulse_period  = TW'(p);
        bus.pulse_count   = NW'(c);
        bus.refractory    = TW'(rf);
    endtask

    task automatic wait_tick(input int unsigned target);
        int n;
        n = 0;
        while (tick_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tick_cnt < target) chk("wait_tick_timeout", tick_cnt, target);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) chk("wait_idle_timeout", 32'(m_busy), 0);
    endtask

    task automatic trigger(input bit keep, output int unsigned t);
        int unsigned s0;
        int n;
        s0 = trig_seq;
        n = 0;
        bus.stim_event = 1'b1;
        while (trig_seq == s0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (trig_seq == s0) chk("trigger_timeout", trig_seq, s0 + 1);
        if (!keep) bus.stim_event = 1'b0;
        t = trig_tick;
    endtask

    int hi_t[16]   = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int busy_t[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int idx_t[16]  = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2};

    task automatic run_basic(input bit change_w);
        int unsigned t;
        set_cfg(2, 3, 5, 2, 4);
        trigger(1'b0, t);
        for (int k = 0; k < 16; k++) begin
            wait_tick(t + k);
            if (change_w && k == 1) bus.pulse_width = TW'(7);
            chk("basic_stim", bus.stim_out, hi_t[k]);
            chk("basic_busy", bus.busy, busy_t[k]);
            chk("basic_index", bus.stim_index, idx_t[k]);
        end
    endtask

    initial begin
        int unsigned t;
        int n;
        bus.stim_event = 1'b0;
        bus.enable = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_stim", bus.stim_out, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_index", bus.stim_index, 0);
        chk("reset_missed", bus.missed_count, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);

        run_basic(1'b1);
        trigger(1'b0, t);
        wait_tick(t + 1); chk("w7_k1_stim", bus.stim_out, 0);
        wait_tick(t + 2); chk("w7_k2_stim", bus.stim_out, 1);
        wait_tick(t + 8); chk("w7_k8_stim", bus.stim_out, 1);
        wait_tick(t + 9); chk("w7_k9_stim", bus.stim_out, 0);
        wait_idle();

        set_cfg(0, 0, 3, 0, 0);
        trigger(1'b0, t);
        chk("zero_k0_stim", bus.stim_out, 1);
        chk("zero_k0_busy", bus.busy, 1);
        chk("zero_k0_index", bus.stim_index, 1);
        wait_tick(t + 1);
        chk("zero_k1_stim", bus.stim_out, 0);
        chk("zero_k1_busy", bus.busy, 0);
        repeat (6) @(negedge clk);

        set_cfg(2, 3, 5, 2, 4);
        trigger(1'b1, t);
        wait_idle();
        bus.stim_event = 1'b0;
`ifdef STIM_TRIGGER_MISSED_COUNT_EN
        chk("lockout_missed", bus.missed_count, 14);
`else
        chk("lockout_missed", bus.missed_count, 0);
`endif
        chk("lockout_index", bus.stim_index, 2);
        wait_tick(tick_cnt + 3);
        chk("lockout_single_train", bus.busy, 0);

        trigger(1'b0, t);
        n = 0;
        while (!m_stim && n < 200) begin @(negedge clk); n++; end
        bus.enable = 1'b0;
        @(negedge clk);
        chk("abort_stim", bus.stim_out, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_index", bus.stim_index, 1);
        bus.enable = 1'b1;
        trigger(1'b0, t);
        wait_idle();
        chk("abort_retrain_index", bus.stim_index, 2);

        trigger(1'b0, t);
        n = 0;
        while (!(m_busy && !m_stim && m_index == 1) && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #2 reset = 1'b1;
        hold_sclk = 1'b1;
        #1;
        chk("areset_stim", bus.stim_out, 0);
        chk("areset_busy", bus.busy, 0);
        chk("areset_index", bus.stim_index, 0);
        chk("areset_missed", bus.missed_count, 0);
        set_cfg(0, 0, 0, 0, 0);
        bus.stim_event = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("release_no_tick_stim", bus.stim_out, 0);
        chk("release_no_tick_busy", bus.busy, 0);
        bus.stim_event = 1'b0;
        hold_sclk = 1'b0;

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            bus.stim_event = ($urandom_range(0, 9) < 2);
            bus.enable = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 29) == 0)
                set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 8),
                        $urandom_range(0, 4), $urandom_range(0, 4));
        end
        bus.stim_event = 1'b0;
        bus.enable = 1'b1;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
